// File: rtl/snn_wb_host_master.sv
// Host-side Wishbone classic master for the SNN accelerator slave port.
// Turns (addr, len, dir) burst commands into one single-beat bus cycle per word.
module snn_wb_host_master #(
    parameter int ADDR_STEP      = 4,
    parameter int LEN_W          = 12,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic             wb_clk_i,
    input  logic             wb_rst_i,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic             cmd_we,
    input  logic [31:0]      cmd_addr,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [31:0]      wr_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [31:0]      rd_data,
    output logic             wbm_cyc_o,
    output logic             wbm_stb_o,
    output logic             wbm_we_o,
    output logic [3:0]       wbm_sel_o,
    output logic [31:0]      wbm_adr_o,
    output logic [31:0]      wbm_dat_o,
    input  logic             wbm_ack_i,
    input  logic [31:0]      wbm_dat_i,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic [2:0]       dbg_state
);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] GET_WDATA  = 3'd1;
    localparam logic [2:0] BUS        = 3'd2;
    localparam logic [2:0] PUSH_RDATA = 3'd3;
    localparam logic [2:0] FINISH     = 3'd4;

    localparam int            TW    = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TLAST = TW'((TIMEOUT_CYCLES > 0) ? TIMEOUT_CYCLES - 1 : 0);
    localparam logic [31:0]   STEP  = 32'(ADDR_STEP);

    logic [2:0]       state;
    logic [31:0]      addr;
    logic [LEN_W-1:0] cnt;
    logic             we_r;
    logic             abort_r;
    logic [TW-1:0]    tcnt;
    logic             ack_hit;
    logic             tmo_hit;
    logic             last_beat;

    // All three streams (cmd, wr, rd) use strict valid/ready: a word moves on the
    // clock edge where both are high; the producer holds its payload until then.
    assign cmd_ready = (state == IDLE);
    assign wr_ready  = (state == GET_WDATA);
    assign rd_valid  = (state == PUSH_RDATA);
    assign busy      = (state != IDLE);
    assign done      = (state == FINISH);
    assign err       = (state == FINISH) && abort_r;
    assign dbg_state = state;
    assign wbm_adr_o = addr;

    // Ack is only honoured while strobing; it also beats a same-cycle timeout.
    assign ack_hit   = wbm_stb_o && wbm_ack_i;
    assign tmo_hit   = (TIMEOUT_CYCLES != 0) && wbm_stb_o && !wbm_ack_i && (tcnt == TLAST);
    assign last_beat = (cnt == LEN_W'(1));

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state     <= IDLE;
            addr      <= '0;
            cnt       <= '0;
            we_r      <= 1'b0;
            abort_r   <= 1'b0;
            tcnt      <= '0;
            rd_data   <= '0;
            wbm_cyc_o <= 1'b0;
            wbm_stb_o <= 1'b0;
            wbm_we_o  <= 1'b0;
            wbm_sel_o <= 4'h0;
            wbm_dat_o <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        addr    <= cmd_addr;
                        cnt     <= cmd_len;
                        we_r    <= cmd_we;
                        abort_r <= 1'b0;
                        if (cmd_len == '0) begin
                            state <= FINISH;
                        end else if (cmd_we) begin
                            state <= GET_WDATA;
                        end else begin
                            state     <= BUS;
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            wbm_sel_o <= 4'hF;
                            wbm_we_o  <= 1'b0;
                        end
                    end
                end
                GET_WDATA: begin
                    if (wr_valid) begin
                        wbm_dat_o <= wr_data;
                        state     <= BUS;
                        wbm_cyc_o <= 1'b1;
                        wbm_stb_o <= 1'b1;
                        wbm_sel_o <= 4'hF;
                        wbm_we_o  <= we_r;
                    end
                end
                BUS: begin
                    if (ack_hit) begin
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_sel_o <= 4'h0;
                        wbm_we_o  <= 1'b0;
                        tcnt      <= '0;
                        if (we_r) begin
                            cnt   <= cnt - LEN_W'(1);
                            addr  <= addr + STEP;
                            state <= last_beat ? FINISH : GET_WDATA;
                        end else begin
                            rd_data <= wbm_dat_i;
                            state   <= PUSH_RDATA;
                        end
                    end else if (tmo_hit) begin
                        // Abandon the burst; unconsumed write words stay with the caller.
                        wbm_cyc_o <= 1'b0;
                        wbm_stb_o <= 1'b0;
                        wbm_sel_o <= 4'h0;
                        wbm_we_o  <= 1'b0;
                        tcnt      <= '0;
                        abort_r   <= 1'b1;
                        state     <= FINISH;
                    end else if (wbm_stb_o) begin
                        tcnt <= tcnt + TW'(1);
                    end
                end
                PUSH_RDATA: begin
                    if (rd_ready) begin
                        cnt  <= cnt - LEN_W'(1);
                        addr <= addr + STEP;
                        if (last_beat) begin
                            state <= FINISH;
                        end else begin
                            state     <= BUS;
                            wbm_cyc_o <= 1'b1;
                            wbm_stb_o <= 1'b1;
                            wbm_sel_o <= 4'hF;
                            wbm_we_o  <= 1'b0;
                        end
                    end
                end
                FINISH: begin
                    state   <= IDLE;
                    abort_r <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_snn_wb_host_master.sv
// Directed bench for snn_wb_host_master against a registered single-cycle-ack slave.
module tb_snn_wb_host_master;

    localparam int LW = 12;

    logic          wb_clk_i = 1'b0;
    logic          wb_rst_i = 1'b1;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_we = 1'b0;
    logic [31:0]   cmd_addr = '0;
    logic [LW-1:0] cmd_len = '0;
    logic          wr_valid = 1'b0;
    logic          wr_ready;
    logic [31:0]   wr_data = '0;
    logic          rd_valid;
    logic          rd_ready = 1'b0;
    logic [31:0]   rd_data;
    logic          wbm_cyc_o;
    logic          wbm_stb_o;
    logic          wbm_we_o;
    logic [3:0]    wbm_sel_o;
    logic [31:0]   wbm_adr_o;
    logic [31:0]   wbm_dat_o;
    logic          wbm_ack_i;
    logic [31:0]   wbm_dat_i;
    logic          busy;
    logic          done;
    logic          err;
    logic [2:0]    dbg_state;

    snn_wb_host_master #(.ADDR_STEP(4), .LEN_W(LW), .TIMEOUT_CYCLES(8)) dut (
        .wb_clk_i(wb_clk_i), .wb_rst_i(wb_rst_i),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
        .wbm_cyc_o(wbm_cyc_o), .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o),
        .wbm_sel_o(wbm_sel_o), .wbm_adr_o(wbm_adr_o), .wbm_dat_o(wbm_dat_o),
        .wbm_ack_i(wbm_ack_i), .wbm_dat_i(wbm_dat_i),
        .busy(busy), .done(done), .err(err), .dbg_state(dbg_state)
    );

    // ---------------- clock ----------------
    always #5 wb_clk_i = ~wb_clk_i;

    // ---------------- slave model ----------------
    logic slave_en = 1'b1;

    function automatic logic [31:0] slave_mem(input logic [31:0] a);
        case (a)
            32'h3000_3000: return 32'h0000_0005;
            32'h3000_3004: return 32'h0000_0009;
            32'hFFFF_FFFC: return 32'h0000_AAAA;
            32'h0000_0000: return 32'h0000_BBBB;
            default:       return 32'hDEAD_0000 ^ a;
        endcase
    endfunction

    always @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            wbm_ack_i <= 1'b0;
            wbm_dat_i <= '0;
        end else begin
            wbm_ack_i <= slave_en && wbm_cyc_o && wbm_stb_o && !wbm_ack_i;
            wbm_dat_i <= slave_mem(wbm_adr_o);
        end
    end

    // ---------------- monitors ----------------
    logic [31:0] log_adr [64];
    logic [31:0] log_dat [64];
    logic        log_we  [64];
    logic [3:0]  log_sel [64];
    logic [31:0] log_rd  [64];
    int n_beats = 0;
    int n_rd = 0;
    int done_cnt = 0;
    int err_cnt = 0;
    int stb_rises = 0;
    logic prev_stb = 1'b0;

    always @(posedge wb_clk_i) begin
        if (wbm_cyc_o && wbm_stb_o && wbm_ack_i) begin
            log_adr[n_beats % 64] <= wbm_adr_o;
            log_dat[n_beats % 64] <= wbm_dat_o;
            log_we[n_beats % 64]  <= wbm_we_o;
            log_sel[n_beats % 64] <= wbm_sel_o;
            n_beats <= n_beats + 1;
        end
        if (rd_valid && rd_ready) begin
            log_rd[n_rd % 64] <= rd_data;
            n_rd <= n_rd + 1;
        end
    end

    always @(negedge wb_clk_i) begin
        if (done) done_cnt <= done_cnt + 1;
        if (err) err_cnt <= err_cnt + 1;
        if (wbm_stb_o && !prev_stb) stb_rises <= stb_rises + 1;
        prev_stb <= wbm_stb_o;
    end

    // ---------------- scoreboard ----------------
    int n_tests = 0;
    int n_fail = 0;
    logic [31:0] exp_q[$];
    logic [31:0] wr_words [8];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic send_cmd(input logic we, input logic [31:0] a, input logic [LW-1:0] len);
        @(negedge wb_clk_i);
        cmd_valid = 1'b1;
        cmd_we    = we;
        cmd_addr  = a;
        cmd_len   = len;
        check("cmd_ready_at_issue", 32'(cmd_ready), 32'd1);
        @(posedge wb_clk_i);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic push_wr(input int n);
        int k;
        for (int i = 0; i < n; i++) begin
            k = 0;
            wr_valid = 1'b1;
            wr_data  = wr_words[i];
            @(negedge wb_clk_i);
            while (!wr_ready && k < 300) begin
                @(negedge wb_clk_i);
                k++;
            end
            check("wr_ready_wait", 32'(wr_ready), 32'd1);
            @(posedge wb_clk_i);
            #1;
        end
        wr_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int k;
        k = 0;
        @(negedge wb_clk_i);
        while (!done && k < 300) begin
            @(negedge wb_clk_i);
            k++;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic wait_rdv(input string tag);
        int k;
        k = 0;
        @(negedge wb_clk_i);
        while (!rd_valid && k < 300) begin
            @(negedge wb_clk_i);
            k++;
        end
        check({tag, "_rd_valid"}, 32'(rd_valid), 32'd1);
    endtask

    task automatic rd_handshake();
        rd_ready = 1'b1;
        @(posedge wb_clk_i);
        #1;
        rd_ready = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no end, want end before 200us");
        $fatal(1, "watchdog");
    end

    // ---------------- directed tests ----------------
    initial begin
        int b, r, d, e, cnt;

        // reset state
        repeat (3) @(negedge wb_clk_i);
        check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_cyc", 32'(wbm_cyc_o), 32'd0);
        check("rst_stb", 32'(wbm_stb_o), 32'd0);
        check("rst_we_sel", {27'd0, wbm_we_o, wbm_sel_o}, 32'd0);
        check("rst_adr", wbm_adr_o, 32'd0);
        check("rst_dat_o", wbm_dat_o, 32'd0);
        check("rst_rd_data", rd_data, 32'd0);
        check("rst_flags", {28'd0, done, err, wr_ready, rd_valid}, 32'd0);
        wb_rst_i = 1'b0;

        // write burst of three words
        b = n_beats; r = stb_rises; d = done_cnt; e = err_cnt;
        wr_words[0] = 32'h11; wr_words[1] = 32'h22; wr_words[2] = 32'h33;
        send_cmd(1'b1, 32'h3000_0000, LW'(3));
        push_wr(3);
        wait_done("wr3");
        check("wr3_err", 32'(err), 32'd0);
        @(negedge wb_clk_i);
        check("wr3_done_once", 32'(done_cnt - d), 32'd1);
        check("wr3_no_err", 32'(err_cnt - e), 32'd0);
        check("wr3_beats", 32'(n_beats - b), 32'd3);
        check("wr3_stb_gaps", 32'(stb_rises - r), 32'd3);
        check("wr3_idle_ready", 32'(cmd_ready), 32'd1);
        exp_q = {32'h3000_0000, 32'h3000_0004, 32'h3000_0008};
        for (int i = 0; i < 3; i++) begin
            check("wr3_adr", log_adr[(b + i) % 64], exp_q.pop_front());
            check("wr3_dat", log_dat[(b + i) % 64], wr_words[i]);
            check("wr3_we_sel", {27'd0, log_we[(b + i) % 64], log_sel[(b + i) % 64]}, 32'h1F);
        end

        // read burst with consumer backpressure on beat 0
        b = n_beats; r = stb_rises; d = done_cnt; e = err_cnt;
        rd_ready = 1'b0;
        send_cmd(1'b0, 32'h3000_3000, LW'(2));
        wait_rdv("rd0");
        check("rd0_data", rd_data, 32'h5);
        for (int i = 0; i < 4; i++) begin
            @(negedge wb_clk_i);
            check("rd0_hold_data", rd_data, 32'h5);
            check("rd0_hold_valid", 32'(rd_valid), 32'd1);
            check("rd0_no_stb", 32'(wbm_stb_o), 32'd0);
        end
        check("rd0_rises", 32'(stb_rises - r), 32'd1);
        rd_handshake();
        wait_rdv("rd1");
        check("rd1_data", rd_data, 32'h9);
        check("rd1_rises", 32'(stb_rises - r), 32'd2);
        rd_handshake();
        wait_done("rd2");
        check("rd2_err", 32'(err), 32'd0);
        @(negedge wb_clk_i);
        check("rd2_done_once", 32'(done_cnt - d), 32'd1);
        check("rd2_beats", 32'(n_beats - b), 32'd2);
        check("rd2_adr0", log_adr[b % 64], 32'h3000_3000);
        check("rd2_adr1", log_adr[(b + 1) % 64], 32'h3000_3004);
        check("rd2_we", {31'd0, log_we[b % 64] | log_we[(b + 1) % 64]}, 32'd0);

        // zero length: done the cycle after accept, no bus activity
        r = stb_rises; d = done_cnt;
        send_cmd(1'b1, 32'h3000_0000, LW'(0));
        @(negedge wb_clk_i);
        check("len0_done", 32'(done), 32'd1);
        check("len0_err", 32'(err), 32'd0);
        @(negedge wb_clk_i);
        check("len0_done_drop", 32'(done), 32'd0);
        check("len0_ready", 32'(cmd_ready), 32'd1);
        check("len0_no_cyc", 32'(stb_rises - r), 32'd0);
        check("len0_done_once", 32'(done_cnt - d), 32'd1);

        // timeout: slave never acks
        slave_en = 1'b0;
        e = err_cnt;
        wr_words[0] = 32'h0000_C0DE;
        send_cmd(1'b1, 32'h3000_4000, LW'(1));
        push_wr(1);
        cnt = 0;
        @(negedge wb_clk_i);
        while (wbm_stb_o && cnt < 50) begin
            cnt++;
            @(negedge wb_clk_i);
        end
        check("tmo_stb_cycles", 32'(cnt), 32'd8);
        check("tmo_cyc_low", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
        check("tmo_done_err", {30'd0, done, err}, 32'd3);
        @(negedge wb_clk_i);
        check("tmo_ready_next", 32'(cmd_ready), 32'd1);
        check("tmo_err_drop", 32'(err), 32'd0);
        check("tmo_err_once", 32'(err_cnt - e), 32'd1);
        slave_en = 1'b1;

        // address wrap on a read burst
        b = n_beats; r = n_rd;
        rd_ready = 1'b1;
        send_cmd(1'b0, 32'hFFFF_FFFC, LW'(2));
        wait_done("wrap");
        rd_ready = 1'b0;
        @(negedge wb_clk_i);
        check("wrap_beats", 32'(n_beats - b), 32'd2);
        check("wrap_adr0", log_adr[b % 64], 32'hFFFF_FFFC);
        check("wrap_adr1", log_adr[(b + 1) % 64], 32'h0000_0000);
        check("wrap_rd0", log_rd[r % 64], 32'h0000_AAAA);
        check("wrap_rd1", log_rd[(r + 1) % 64], 32'h0000_BBBB);

        // reset during beat 2 of a four-word write
        b = n_beats; d = done_cnt;
        wr_words[0] = 32'h1; wr_words[1] = 32'h2; wr_words[2] = 32'h3; wr_words[3] = 32'h4;
        send_cmd(1'b1, 32'h3000_0000, LW'(4));
        push_wr(2);
        @(negedge wb_clk_i);
        check("rstmid_stb_before", 32'(wbm_stb_o), 32'd1);
        wb_rst_i = 1'b1;
        @(posedge wb_clk_i);
        #1;
        check("rstmid_cyc_stb", {30'd0, wbm_cyc_o, wbm_stb_o}, 32'd0);
        @(negedge wb_clk_i);
        wb_rst_i = 1'b0;
        repeat (3) @(negedge wb_clk_i);
        check("rstmid_ready", 32'(cmd_ready), 32'd1);
        check("rstmid_no_done", 32'(done_cnt - d), 32'd0);
        wr_words[0] = 32'h77;
        send_cmd(1'b1, 32'h3000_0010, LW'(1));
        push_wr(1);
        wait_done("fresh");
        check("fresh_err", 32'(err), 32'd0);
        @(negedge wb_clk_i);
        check("fresh_beats", 32'(n_beats - b), 32'd2);
        check("fresh_adr", log_adr[(b + 1) % 64], 32'h3000_0010);
        check("fresh_dat", log_dat[(b + 1) % 64], 32'h77);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
